// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the arbitrated alu: function selects, status bit positions, arbiter state.
// Status is packed {v,c,n,z} so ST_Z is the LSB.
package alu_arbiter_pkg;

  localparam int DW = 64;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_XOR = 3'd3,
    OP_LSL = 3'd4,
    OP_LSR = 3'd5
  } alu_op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the alu arbiter: per-requester operands in flat slices, one-hot grant/response.
// master = requesters, slave = arbiter.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [DW*NREQ-1:0] req_a;
  logic [DW*NREQ-1:0] req_b;
  logic [5*NREQ-1:0]  req_fs;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_f;
  logic [3:0]         rsp_status;
  logic [NREQ-1:0]    lock_owner;
  logic               lock_timeout;

  modport master (
    output req_valid, req_lock, req_a, req_b, req_fs, req_cin,
    input  req_ready, rsp_valid, rsp_f, rsp_status, lock_owner, lock_timeout
  );

  modport slave (
    input  req_valid, req_lock, req_a, req_b, req_fs, req_cin,
    output req_ready, rsp_valid, rsp_f, rsp_status, lock_owner, lock_timeout
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 64-bit alu; fs[1:0] invert operands, fs[4:2] pick the op, 6/7 yield zero.
// Carry/overflow are only produced by the adder; shifts take raw a and b[5:0].
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [4:0]    fs,
  input  logic          cin,
  output logic [DW-1:0] f,
  output logic [3:0]    status
);
  logic [DW-1:0] ai, bi;
  logic [DW:0]   sum;
  logic          c, v;

  always_comb begin
    ai  = fs[0] ? ~a : a;
    bi  = fs[1] ? ~b : b;
    sum = {1'b0, ai} + {1'b0, bi} + {{DW{1'b0}}, cin};
    f   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (fs[4:2])
      OP_AND: f = ai & bi;
      OP_OR:  f = ai | bi;
      OP_ADD: begin
        f = sum[DW-1:0];
        c = sum[DW];
        v = (ai[DW-1] == bi[DW-1]) && (sum[DW-1] != ai[DW-1]);
      end
      OP_XOR: f = ai ^ bi;
      OP_LSL: f = a << b[5:0];
      OP_LSR: f = a >> b[5:0];
      default: f = '0;
    endcase
    status       = '0;
    status[ST_Z] = (f == '0);
    status[ST_N] = f[DW-1];
    status[ST_C] = c;
    status[ST_V] = v;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter with optional multi-op lock in front of one shared alu; 2-cycle latency, 1 op/cycle.
// Requesters are backpressured through req_ready; responses are single-cycle pulses with no backpressure.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 15
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, win, cand;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          found, acc, lock_in, expire;
  logic [NREQ-1:0] ready;

  logic          iss_vld, iss_cin;
  logic [DW-1:0] iss_a, iss_b, alu_f;
  logic [4:0]    iss_fs;
  logic [PW-1:0] iss_id;
  logic [3:0]    alu_st;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Grant and status outputs; reset masks everything so nothing is offered while held in reset.
  always_comb begin : grant_out
    ready = '0;
    win   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    if (state_q == IDLE) begin
      for (int i = 1; i <= NREQ; i++) begin
        cand = rr_idx(ptr_q, i);
        if (!found && bus.req_valid[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end else begin
      win   = owner_q;
      found = bus.req_valid[owner_q];
    end
    if (found && reset_n) ready = ONE << win;
    acc     = |(bus.req_valid & ready);
    lock_in = bus.req_lock[win];
    // An owner accept on the last lock cycle takes precedence over expiry.
    expire  = (state_q == LOCKED) && !acc && (cnt_q == CW'(LOCK_MAX - 1));
    bus.req_ready    = ready;
    bus.lock_owner   = ((state_q == LOCKED) && reset_n) ? (ONE << owner_q) : '0;
    bus.lock_timeout = expire && reset_n;
  end

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          ptr_d = win;
          if (lock_in) begin
            state_d = LOCKED;
            owner_d = win;
            cnt_d   = '0;
          end
        end
      end
      LOCKED: begin
        if (acc) begin
          cnt_d = '0;
          if (!lock_in) state_d = IDLE;
        end else if (expire) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin : state_reg
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin : pipe_reg
    if (!reset_n) begin
      iss_vld        <= 1'b0;
      iss_a          <= '0;
      iss_b          <= '0;
      iss_fs         <= '0;
      iss_cin        <= 1'b0;
      iss_id         <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_f      <= '0;
      bus.rsp_status <= '0;
    end else begin
      iss_vld <= acc;
      if (acc) begin
        iss_a   <= bus.req_a[DW*win +: DW];
        iss_b   <= bus.req_b[DW*win +: DW];
        iss_fs  <= bus.req_fs[5*win +: 5];
        iss_cin <= bus.req_cin[win];
        iss_id  <= win;
      end
      bus.rsp_valid  <= iss_vld ? (ONE << iss_id) : '0;
      bus.rsp_f      <= alu_f;
      bus.rsp_status <= alu_st;
    end
  end

  alu_arbiter_alu u_alu (
    .a      (iss_a),
    .b      (iss_b),
    .fs     (iss_fs),
    .cin    (iss_cin),
    .f      (alu_f),
    .status (alu_st)
  );
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NREQ=2, LOCK_MAX=3): one table row per cycle plus reset sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  l;
    logic [63:0] a0, b0, a1, b1;
    logic [4:0]  fs;
    logic        cin;
    logic [1:0]  rdy;
    logic [1:0]  rsp;
    logic [63:0] f;
    logic [3:0]  st;
    logic [1:0]  own;
    logic        to;
  } vec_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  vec_t tbl[24];

  alu_arbiter_if #(.NREQ(2)) bus ();

  alu_arbiter #(.NREQ(2), .LOCK_MAX(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t V(input logic [1:0] v, input logic [1:0] l,
                             input logic [63:0] a0, input logic [63:0] b0,
                             input logic [63:0] a1, input logic [63:0] b1,
                             input logic [4:0] fs, input logic cin,
                             input logic [1:0] rdy, input logic [1:0] rsp,
                             input logic [63:0] f, input logic [3:0] st,
                             input logic [1:0] own, input logic to);
    vec_t t;
    t.v = v; t.l = l; t.a0 = a0; t.b0 = b0; t.a1 = a1; t.b1 = b1;
    t.fs = fs; t.cin = cin; t.rdy = rdy; t.rsp = rsp; t.f = f; t.st = st;
    t.own = own; t.to = to;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [63:0] a0,
                       input logic [63:0] b0, input logic [63:0] a1, input logic [63:0] b1,
                       input logic [4:0] fs, input logic cin);
    bus.req_valid = v;
    bus.req_lock  = l;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    bus.req_fs    = {fs, fs};
    bus.req_cin   = {cin, cin};
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    drive(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0);

    tbl[0]  = V(2'b11, 2'b00, 64'd5, 64'd7, 64'd9, 64'd9, FS_ADD, 1'b0, 2'b01, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[1]  = V(2'b10, 2'b00, 64'd0, 64'd0, 64'd9, 64'd9, FS_SUB, 1'b1, 2'b10, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[2]  = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b01, 64'd12, 4'b0000, 2'b00, 1'b0);
    tbl[3]  = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b10, 64'd0, 4'b0101, 2'b00, 1'b0);
    tbl[4]  = V(2'b11, 2'b00, 64'd1, 64'd2, 64'd10, 64'd20, FS_ADD, 1'b0, 2'b01, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[5]  = V(2'b11, 2'b00, 64'd3, 64'd4, 64'd30, 64'd40, FS_ADD, 1'b0, 2'b10, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[6]  = V(2'b11, 2'b00, 64'd5, 64'd6, 64'd7, 64'd8, FS_XOR, 1'b0, 2'b01, 2'b01, 64'd3, 4'b0000, 2'b00, 1'b0);
    tbl[7]  = V(2'b11, 2'b00, 64'd1, 64'd1, 64'd3, 64'h44, FS_LSL, 1'b0, 2'b10, 2'b10, 64'd70, 4'b0000, 2'b00, 1'b0);
    tbl[8]  = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b01, 64'd3, 4'b0000, 2'b00, 1'b0);
    tbl[9]  = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b10, 64'd48, 4'b0000, 2'b00, 1'b0);
    // Lock by req1 left idle until the 3-cycle limit forces release.
    tbl[10] = V(2'b10, 2'b10, 64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, FS_ADD, 1'b0, 2'b10, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[11] = V(2'b01, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b00, 64'd0, 4'h0, 2'b10, 1'b0);
    tbl[12] = V(2'b01, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b10, 64'h8000_0000_0000_0000, 4'b1010, 2'b10, 1'b0);
    tbl[13] = V(2'b01, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b00, 64'd0, 4'h0, 2'b10, 1'b1);
    tbl[14] = V(2'b01, 2'b00, 64'd5, 64'd5, 64'd0, 64'd0, 5'b11000, 1'b0, 2'b01, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[15] = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[16] = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b01, 64'd0, 4'b0001, 2'b00, 1'b0);
    // Second lock: owner unlocks exactly on the expiry cycle, so no timeout pulse.
    tbl[17] = V(2'b10, 2'b10, 64'd0, 64'd0, 64'd8, 64'd2, FS_LSR, 1'b0, 2'b10, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[18] = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b00, 64'd0, 4'h0, 2'b10, 1'b0);
    tbl[19] = V(2'b01, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b10, 64'd2, 4'b0000, 2'b10, 1'b0);
    tbl[20] = V(2'b11, 2'b00, 64'd0, 64'd0, 64'd3, 64'd5, FS_SUB, 1'b1, 2'b10, 2'b00, 64'd0, 4'h0, 2'b10, 1'b0);
    tbl[21] = V(2'b01, 2'b00, 64'hF0, 64'h0F, 64'd0, 64'd0, 5'b00011, 1'b0, 2'b01, 2'b00, 64'd0, 4'h0, 2'b00, 1'b0);
    tbl[22] = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 2'b00, 1'b0);
    tbl[23] = V(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0, 2'b00, 2'b01, 64'hFFFF_FFFF_FFFF_FF00, 4'b0010, 2'b00, 1'b0);

    // Held in reset with both requesters valid: nothing granted, nothing returned.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(2'b11, 2'b00, 64'd1, 64'd1, 64'd2, 64'd2, FS_ADD, 1'b0);
      #1;
      chk($sformatf("reset%0d ready", i), 64'(bus.req_ready), 64'd0);
      chk($sformatf("reset%0d rsp_valid", i), 64'(bus.rsp_valid), 64'd0);
      chk($sformatf("reset%0d lock_timeout", i), 64'(bus.lock_timeout), 64'd0);
    end

    for (int r = 0; r < 24; r++) begin
      @(negedge clock);
      reset_n = 1'b1;
      drive(tbl[r].v, tbl[r].l, tbl[r].a0, tbl[r].b0, tbl[r].a1, tbl[r].b1, tbl[r].fs, tbl[r].cin);
      #1;
      chk($sformatf("row%0d ready", r), 64'(bus.req_ready), 64'(tbl[r].rdy));
      chk($sformatf("row%0d rsp_valid", r), 64'(bus.rsp_valid), 64'(tbl[r].rsp));
      chk($sformatf("row%0d lock_owner", r), 64'(bus.lock_owner), 64'(tbl[r].own));
      chk($sformatf("row%0d lock_timeout", r), 64'(bus.lock_timeout), 64'(tbl[r].to));
      if (tbl[r].rsp != 2'b00) begin
        chk($sformatf("row%0d rsp_f", r), bus.rsp_f, tbl[r].f);
        chk($sformatf("row%0d rsp_status", r), 64'(bus.rsp_status), 64'(tbl[r].st));
      end
    end

    // Reset right after an accept must drop the op and restore requester 0 priority.
    @(negedge clock);
    drive(2'b01, 2'b00, 64'd1, 64'd1, 64'd0, 64'd0, FS_ADD, 1'b0);
    #1;
    chk("inflight accept ready", 64'(bus.req_ready), 64'b01);
    @(negedge clock);
    reset_n = 1'b0;
    drive(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0);
    #1;
    chk("inflight rsp_valid k+1", 64'(bus.rsp_valid), 64'd0);
    @(negedge clock);
    #1;
    chk("inflight rsp_valid k+2", 64'(bus.rsp_valid), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(2'b11, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0);
    #1;
    chk("post-reset grant", 64'(bus.req_ready), 64'b01);
    chk("post-reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clock);
    drive(2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, FS_ADD, 1'b0);
    @(negedge clock);
    #1;
    chk("post-reset rsp id", 64'(bus.rsp_valid), 64'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
